// File: rtl/sram_1r1w_fifo_ctrl.sv
// Valid/ready FIFO built on an external 1R1W SRAM macro with one-cycle read latency.
// A two-entry skid buffer behind the macro read port hides the latency for full throughput.
module sram_1r1w_fifo_ctrl #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enq_valid,
    output logic                enq_ready,
    input  logic [DATA_W-1:0]   enq_bits,
    output logic                deq_valid,
    input  logic                deq_ready,
    output logic [DATA_W-1:0]   deq_bits,
    output logic [ADDR_W+1:0]   count,
    output logic [ADDR_W-1:0]   W0_addr,
    output logic                W0_en,
    output logic [DATA_W-1:0]   W0_data,
    output logic [ADDR_W-1:0]   R0_addr,
    output logic                R0_en,
    input  logic [DATA_W-1:0]   R0_data
);

    localparam logic [ADDR_W:0] RAM_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic [DATA_W-1:0] skid0_q, skid0_d;
    logic [DATA_W-1:0] skid1_q, skid1_d;

    logic       enq_fire;
    logic       deq_fire;
    logic       rd_issue;
    logic [1:0] occ;

    always_comb begin
        enq_ready = (ram_cnt_q != RAM_FULL);
        enq_fire  = enq_valid & enq_ready;
        deq_valid = (skid_cnt_q != 2'd0);
        deq_bits  = skid0_q;
        deq_fire  = deq_valid & deq_ready;
        occ       = skid_cnt_q + {1'b0, inflight_q};
        // A pop this cycle frees a slot, so a read may issue even when skid+inflight is 2.
        rd_issue  = (ram_cnt_q != '0) & ((occ < 2'd2) | deq_fire);

        W0_en   = enq_fire;
        W0_addr = wptr_q;
        W0_data = enq_bits;
        R0_en   = rd_issue;
        R0_addr = rptr_q;

        count = {1'b0, ram_cnt_q}
              + {{ADDR_W{1'b0}}, skid_cnt_q}
              + {{(ADDR_W+1){1'b0}}, inflight_q};
    end

    always_comb begin
        wptr_d     = enq_fire ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = rd_issue ? rptr_q + 1'b1 : rptr_q;
        ram_cnt_d  = ram_cnt_q + {{ADDR_W{1'b0}}, enq_fire} - {{ADDR_W{1'b0}}, rd_issue};
        inflight_d = rd_issue;
        skid_cnt_d = skid_cnt_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;

        // Returning read data (inflight) lands in the tail slot left after any pop.
        unique case ({deq_fire, inflight_q})
            2'b10: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b01: begin
                if (skid_cnt_q == 2'd0) skid0_d = R0_data;
                else                    skid1_d = R0_data;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = R0_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = R0_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
        end
    end

    // Payload storage carries no reset; skid_cnt_q alone decides what is valid.
    always_ff @(posedge clock) begin
        skid0_q <= skid0_d;
        skid1_q <= skid1_d;
    end

endmodule

// File: tb/tb_sram_1r1w_fifo_ctrl.sv
// Bench for sram_1r1w_fifo_ctrl: macro model with garbage on unread cycles,
// queue-based reference model, vector table and directed corner sequences.
module tb_sram_1r1w_fifo_ctrl;
    localparam int DATA_W = 10;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_bits = '0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [DATA_W-1:0] deq_bits;
    logic [ADDR_W+1:0] count;
    logic [ADDR_W-1:0] W0_addr;
    logic              W0_en;
    logic [DATA_W-1:0] W0_data;
    logic [ADDR_W-1:0] R0_addr;
    logic              R0_en;
    logic [DATA_W-1:0] R0_data;

    sram_1r1w_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
    );

    always #5 clock = ~clock;

    // Macro: registered read, unread cycles return random garbage.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (R0_en) R0_data <= mem[R0_addr];
        else       R0_data <= DATA_W'($urandom);
        if (W0_en) mem[W0_addr] <= W0_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: where each accepted item currently sits.
    logic [DATA_W-1:0] ram_q[$];
    logic [DATA_W-1:0] fly_q[$];
    logic [DATA_W-1:0] skid_q[$];
    int wr_n = 0;
    int rd_n = 0;
    int wraps = 0;
    int prev_waddr = -1;

    logic s_er, s_dv, s_ef, s_df, s_r0en, s_w0en;
    logic [DATA_W-1:0] s_db;
    int s_cnt;

    task automatic model_clear();
        ram_q.delete(); fly_q.delete(); skid_q.delete();
        wr_n = 0; rd_n = 0; prev_waddr = -1;
    endtask

    task automatic step(input logic ev, input logic [DATA_W-1:0] eb, input logic dr);
        logic m_er, m_dv, m_ef, m_df, m_rd;
        @(negedge clock);
        enq_valid = ev; enq_bits = eb; deq_ready = dr;
        #1;
        s_er = enq_ready; s_dv = deq_valid; s_db = deq_bits; s_cnt = int'(count);
        s_r0en = R0_en; s_w0en = W0_en;
        s_ef = enq_valid & enq_ready; s_df = deq_valid & deq_ready;
        if (W0_en) begin
            if (prev_waddr == DEPTH-1 && int'(W0_addr) == 0) wraps++;
            prev_waddr = int'(W0_addr);
        end

        m_er = (ram_q.size() != DEPTH);
        m_dv = (skid_q.size() != 0);
        m_ef = ev && m_er;
        m_df = m_dv && dr;
        m_rd = (ram_q.size() != 0) && ((skid_q.size() + fly_q.size() < 2) || m_df);

        chk("enq_ready", int'(enq_ready), int'(m_er));
        chk("deq_valid", int'(deq_valid), int'(m_dv));
        if (m_dv) chk("deq_bits", int'(deq_bits), int'(skid_q[0]));
        chk("count", int'(count), ram_q.size() + fly_q.size() + skid_q.size());
        chk("W0_en", int'(W0_en), int'(m_ef));
        if (m_ef) begin
            chk("W0_addr", int'(W0_addr), wr_n % DEPTH);
            chk("W0_data", int'(W0_data), int'(eb));
        end
        chk("R0_en", int'(R0_en), int'(m_rd));
        if (m_rd) chk("R0_addr", int'(R0_addr), rd_n % DEPTH);

        @(posedge clock);
        if (m_df) void'(skid_q.pop_front());
        if (fly_q.size() != 0) skid_q.push_back(fly_q.pop_front());
        if (m_rd) begin fly_q.push_back(ram_q.pop_front()); rd_n++; end
        if (m_ef) begin ram_q.push_back(eb); wr_n++; end
    endtask

    task automatic do_reset();
        @(negedge clock);
        enq_valid = 1'b0; deq_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_deq_valid", int'(deq_valid), 0);
        chk("rst_W0_en", int'(W0_en), 0);
        chk("rst_R0_en", int'(R0_en), 0);
        chk("rst_enq_ready", int'(enq_ready), 1);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic              ev;
        logic [DATA_W-1:0] eb;
        logic              dr;
        logic              x_er;
        logic              x_dv;
        logic [DATA_W-1:0] x_db;
        int                x_cnt;
        logic              x_r0en;
        logic              x_w0en;
    } vec_t;

    vec_t tbl[6];
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] sd[100];

    initial begin
        int acc_n, acc_bad, pulses, v, errs;

        // Single enqueue of 0x155 into an empty FIFO.
        tbl[0] = '{1'b1, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h155, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0, 1'b0};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].ev, tbl[i].eb, tbl[i].dr);
            chk($sformatf("vec%0d_enq_ready", i), int'(s_er), int'(tbl[i].x_er));
            chk($sformatf("vec%0d_deq_valid", i), int'(s_dv), int'(tbl[i].x_dv));
            if (tbl[i].x_dv) chk($sformatf("vec%0d_deq_bits", i), int'(s_db), int'(tbl[i].x_db));
            chk($sformatf("vec%0d_count", i), s_cnt, tbl[i].x_cnt);
            chk($sformatf("vec%0d_R0_en", i), int'(s_r0en), int'(tbl[i].x_r0en));
            chk($sformatf("vec%0d_W0_en", i), int'(s_w0en), int'(tbl[i].x_w0en));
        end

        // Reset mid-stream with 5 entries held, then 0x2A after reset.
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(100 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("pre_rst_count", s_cnt, 5);
        do_reset();
        step(1'b1, 10'h02A, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("post_rst_dv_t1", int'(s_dv), 0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_dv_t2", int'(s_dv), 0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_dv_t3", int'(s_dv), 1);
        chk("post_rst_bits", int'(s_db), 'h2A);
        step(1'b0, '0, 1'b1);

        // Fill with deq_ready low, offering 0..11.
        do_reset();
        acc_n = 0; acc_bad = 0; pulses = 0; wraps = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, DATA_W'(i), 1'b0);
            if (s_ef) begin
                if (i != acc_n) acc_bad++;
                acc_n++;
            end
            if (s_r0en) pulses++;
        end
        chk("fill_accepted", acc_n, 10);
        chk("fill_order", acc_bad, 0);
        chk("fill_r0_pulses", pulses, 2);
        chk("fill_count", s_cnt, 10);
        chk("fill_enq_ready", int'(s_er), 0);

        // Drain from full while feeding 10..29.
        v = 10;
        got.delete();
        for (int c = 0; c < 200 && got.size() < 30; c++) begin
            step(v < 30, DATA_W'(v), 1'b1);
            if (s_ef) v++;
            if (s_df) got.push_back(s_db);
        end
        chk("drain_items", got.size(), 30);
        errs = 0;
        foreach (got[k]) if (int'(got[k]) != k) errs++;
        chk("drain_order", errs, 0);
        chk("waddr_wraps_ge2", int'(wraps >= 2), 1);

        // Streaming, 100 cycles of random data.
        do_reset();
        for (int i = 0; i < 100; i++) sd[i] = DATA_W'($urandom);
        got.delete();
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, sd[c], 1'b1);
            if (!s_ef) errs++;
            if (c >= 3 && (!s_df || s_cnt != 3)) errs++;
            if (s_df) got.push_back(s_db);
        end
        chk("stream_no_bubble", errs, 0);
        chk("stream_items", got.size(), 97);
        errs = 0;
        foreach (got[k]) if (got[k] != sd[k]) errs++;
        chk("stream_data", errs, 0);

        // Random toggling against the queue model.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            step(($urandom % 3) != 0, DATA_W'($urandom), ($urandom % 2) == 0);
        end
        for (int c = 0; c < 40; c++) step(1'b0, '0, 1'b1);
        chk("rand_drained_count", s_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
